an_mux_sequencer: RTL and testbench

Scans the analog-in multiplexer across a programmable address range and collects one 12-bit ADC conversion per channel. For each channel it drives the mux address and enable, waits a settle time, pulses the ADC sample request, then waits for the conversion-updated strobe or a timeout. It sits inside `mbed_tester` between the register interface (start/abort/range) and the `an_mux_*` pin controls plus the ADC measurement inputs.

---
 rtl/an_mux_sequencer_pkg.sv | 9 +
 rtl/an_mux_sequencer_if.sv | 22 ++
 rtl/an_mux_sequencer_timer.sv | 15 +
 rtl/an_mux_sequencer.sv | 79 +++++++
 tb/tb_an_mux_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/an_mux_sequencer_pkg.sv
// an_mux_pkg: shared state encoding and constants for the analog mux sequencer
package an_mux_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, WAIT, REPORT} state_t;
  localparam int MEAS_WIDTH = 12;
  localparam logic [MEAS_WIDTH-1:0] TIMEOUT_DATA = '0;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/an_mux_sequencer_if.sv
// an_mux_sequencer_if: mux pin controls, ADC measurement inputs and result bus
interface an_mux_sequencer_if
  import an_mux_pkg::*;
#(parameter int AN_MUX_WIDTH = 8);
  logic an_mux_enable;
  logic [AN_MUX_WIDTH-1:0] an_mux_addr;
  logic sample_adc;
  logic [MEAS_WIDTH-1:0] an_mux_analogin_measurement;
  logic an_mux_analogin_updated;
  logic result_valid;
  logic [AN_MUX_WIDTH-1:0] result_addr;
  logic [MEAS_WIDTH-1:0] result_data;
  logic result_timeout;
  modport master (
    output an_mux_enable, an_mux_addr, sample_adc, result_valid, result_addr, result_data, result_timeout,
    input an_mux_analogin_measurement, an_mux_analogin_updated
  );
  modport slave (
    input an_mux_enable, an_mux_addr, sample_adc, result_valid, result_addr, result_data, result_timeout,
    output an_mux_analogin_measurement, an_mux_analogin_updated
  );
endinterface

// File: rtl/an_mux_sequencer_timer.sv
// cycle_timer: loadable down-counter that holds at zero and flags expiry
module cycle_timer #(parameter int W = 8) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [W-1:0] load_val,
  output logic expired
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (load) count <= load_val;
    else if (!expired) count <= count - W'(1);
  assign expired = count == '0;
endmodule

// File: rtl/an_mux_sequencer.sv
// an_mux_sequencer: scans the analog mux over an address range, one ADC conversion per channel
module an_mux_sequencer
  import an_mux_pkg::*;
#(
  parameter int AN_MUX_WIDTH   = 8,
  parameter int SETTLE_CYCLES  = 100,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic continuous,
  input  logic [AN_MUX_WIDTH-1:0] first_addr,
  input  logic [AN_MUX_WIDTH-1:0] last_addr,
  an_mux_sequencer_if.master bus,
  output logic busy,
  output logic done
);
  localparam int TW = max_int(1, $clog2(max_int(SETTLE_CYCLES, TIMEOUT_CYCLES)));
  state_t state, state_n;
  logic [AN_MUX_WIDTH-1:0] addr, first_q, last_q;
  logic expired, last_ch;
  assign last_ch = addr == last_q;
  assign bus.an_mux_addr = addr;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SETTLE : IDLE;
      SETTLE:  state_n = expired ? SAMPLE : SETTLE;
      SAMPLE:  state_n = WAIT;
      WAIT:    state_n = (bus.an_mux_analogin_updated || expired) ? REPORT : WAIT;
      REPORT:  state_n = (!last_ch || continuous) ? SETTLE : IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  // reloaded on every state change; only the SETTLE and WAIT loads are ever consumed
  cycle_timer #(.W(TW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(state_n != state),
    .load_val(state_n == WAIT ? TW'(TIMEOUT_CYCLES - 1) : TW'(SETTLE_CYCLES - 1)),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      first_q <= '0;
      last_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bus.an_mux_enable <= 1'b0;
      bus.sample_adc <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result_addr <= '0;
      bus.result_data <= '0;
      bus.result_timeout <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      bus.an_mux_enable <= state_n != IDLE;
      bus.sample_adc <= state_n == SAMPLE;
      bus.result_valid <= state_n == REPORT;
      done <= state_n == REPORT && last_ch;
      if (state == IDLE && state_n == SETTLE) begin
        first_q <= first_addr;
        last_q <= last_addr;
        addr <= first_addr;
      end else if (state == REPORT && state_n == SETTLE)
        addr <= last_ch ? first_q : addr + AN_MUX_WIDTH'(1);
      if (state_n == REPORT) begin
        bus.result_addr <= addr;
        bus.result_data <= bus.an_mux_analogin_updated ? bus.an_mux_analogin_measurement : TIMEOUT_DATA;
        bus.result_timeout <= !bus.an_mux_analogin_updated;
      end
    end
endmodule

// File: tb/tb_an_mux_sequencer.sv
// tb_an_mux_sequencer: directed scan scenarios with an ADC model and a result scoreboard
module tb_an_mux_sequencer;
  typedef struct packed {
    logic [7:0]  a;
    logic [11:0] d;
    logic        to;
    logic        dn;
  } exp_t;
  logic clk, rst, start, abort, continuous, busy, done;
  logic [7:0] first_addr, last_addr;
  logic [11:0] meas;
  logic adc_on, adc_upd, inj_upd, prev_en, prev_rv;
  int total, bad, cyc, addr_cyc, samp_cyc, rv_cnt, base;
  exp_t q[$];
  an_mux_sequencer_if #(.AN_MUX_WIDTH(8)) bus();
  assign bus.an_mux_analogin_measurement = meas;
  assign bus.an_mux_analogin_updated = adc_upd | inj_upd;
  an_mux_sequencer #(.AN_MUX_WIDTH(8), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .first_addr(first_addr), .last_addr(last_addr), .bus(bus), .busy(busy), .done(done)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push_range(input logic [7:0] f, input logic [7:0] l, input logic to);
    logic [7:0] a;
    a = f;
    for (int n = 0; n < 256; n++) begin
      q.push_back(exp_t'{a, to ? 12'h000 : {4'hA, a}, to, a == l});
      if (a == l) break;
      a++;
    end
  endtask
  task automatic start_scan(input logic [7:0] f, input logic [7:0] l, input logic cont, input logic to);
    @(negedge clk);
    first_addr = f;
    last_addr = l;
    continuous = cont;
    start = 1'b1;
    push_range(f, l, to);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle(input int limit);
    int n;
    for (n = 0; n < limit; n++) begin
      @(negedge clk);
      #1;
      if (!busy) break;
    end
    chk("idle_in_time", 32'(n < limit), 1);
    chk("queue_drained", q.size(), 0);
    chk("enable_low", bus.an_mux_enable, 0);
  endtask
  // ADC model: answers three cycles after each sample request with 0xA<addr>
  initial begin
    adc_upd = 1'b0;
    meas = '0;
    forever begin
      @(negedge clk);
      if (adc_on && bus.sample_adc === 1'b1) begin
        logic [7:0] a;
        a = bus.an_mux_addr;
        repeat (3) @(negedge clk);
        meas = {4'hA, a};
        adc_upd = 1'b1;
        @(negedge clk);
        adc_upd = 1'b0;
      end
    end
  end
  initial begin
    exp_t e;
    prev_en = 1'b0;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.an_mux_enable === 1'b1 && (!prev_en || prev_rv)) addr_cyc = cyc;
      if (bus.sample_adc === 1'b1) begin
        chk("settle_gap", cyc - addr_cyc, 4);
        samp_cyc = cyc;
      end
      if (bus.result_valid === 1'b1) begin
        rv_cnt++;
        total++;
        assert (q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_result addr=%0h exp=none", bus.result_addr);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("result_addr", bus.result_addr, e.a);
          chk("result_data", bus.result_data, e.d);
          chk("result_timeout", bus.result_timeout, e.to);
          chk("done_with_result", done, e.dn);
          if (e.to) chk("timeout_gap", cyc - samp_cyc, 17);
        end
      end else if (done === 1'b1) chk("done_without_result", done, 0);
      prev_en = bus.an_mux_enable === 1'b1;
      prev_rv = bus.result_valid === 1'b1;
    end
  end
  initial begin
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    continuous = 1'b0;
    first_addr = '0;
    last_addr = '0;
    adc_on = 1'b1;
    inj_upd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_enable", bus.an_mux_enable, 0);
    chk("rst_addr", bus.an_mux_addr, 0);
    chk("rst_sample", bus.sample_adc, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", bus.result_timeout, 0);
    chk("rst_data", bus.result_data, 0);
    start_scan(8'd2, 8'd4, 1'b0, 1'b0);
    chk("busy_after_start", busy, 1);
    chk("addr_after_start", bus.an_mux_addr, 2);
    wait_idle(200);
    start_scan(8'd254, 8'd1, 1'b0, 1'b0);
    wait_idle(300);
    adc_on = 1'b0;
    start_scan(8'd7, 8'd7, 1'b0, 1'b1);
    @(negedge clk);
    inj_upd = 1'b1;
    @(negedge clk);
    inj_upd = 1'b0;
    wait_idle(100);
    adc_on = 1'b1;
    repeat (5) @(negedge clk);
    base = rv_cnt;
    first_addr = 8'd3;
    last_addr = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && bus.sample_adc !== 1'b1; i++) @(negedge clk);
    chk("abort_sample_seen", bus.sample_adc, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_enable", bus.an_mux_enable, 0);
    chk("abort_sample", bus.sample_adc, 0);
    chk("abort_valid", bus.result_valid, 0);
    chk("abort_done", done, 0);
    repeat (6) @(negedge clk);
    chk("abort_no_result", rv_cnt - base, 0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_enable", bus.an_mux_enable, 0);
    repeat (5) @(negedge clk);
    base = rv_cnt;
    start_scan(8'd10, 8'd11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    first_addr = 8'd20;
    last_addr = 8'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(100);
    chk("busy_start_ignored", rv_cnt - base, 2);
    base = rv_cnt;
    start_scan(8'd5, 8'd5, 1'b1, 1'b0);
    push_range(8'd5, 8'd5, 1'b0);
    push_range(8'd5, 8'd5, 1'b0);
    for (int i = 0; i < 100 && rv_cnt < base + 2; i++) begin
      @(negedge clk);
      #1;
    end
    chk("cont_two_passes", rv_cnt - base, 2);
    @(negedge clk);
    continuous = 1'b0;
    wait_idle(100);
    chk("cont_three_passes", rv_cnt - base, 3);
    first_addr = 8'd6;
    last_addr = 8'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_enable", bus.an_mux_enable, 0);
    chk("async_rst_addr", bus.an_mux_addr, 0);
    chk("async_rst_data", bus.result_data, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
